layer_reader: RTL and testbench
===============================

LAYER_READER -- requirements
Module: layer_reader

Interface
REQ-001 Parameter SIZE, default 16, sets the bit width of one neuron value.
REQ-002 Parameter LAYER_SZ, default 10, sets the number of neurons per layer; LAYER_SZ >= 1.
REQ-003 Derived constant ADDR_W = max(1, clog2(LAYER_SZ)) SHALL size the index.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to snapshot and stream one layer.
REQ-007 values  in  LAYER_SZ x SIZE (packed, element 0 first)  parallel neuron values of the layer.
REQ-008 out_valid  out  1  out_data/out_index/out_last are valid.
REQ-009 out_ready  in  1  downstream accepts the current element.
REQ-010 out_data  out  SIZE  neuron value being streamed.
REQ-011 out_index  out  ADDR_W  neuron index of out_data.
REQ-012 out_last  out  1  current element is index LAYER_SZ-1.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  single-cycle pulse after the final transfer.

Function
REQ-015 FSM states SHALL be IDLE, STREAM, DONE.
REQ-016 IDLE with start=1 SHALL copy all of values into an internal snapshot buffer, clear the index to 0, and enter STREAM on the next edge.
REQ-017 The first out_valid SHALL assert exactly 1 cycle after the start cycle.
REQ-018 Changes on values after the start cycle SHALL NOT affect streamed data.
REQ-019 In STREAM, out_valid=1, out_data=snapshot[index], out_index=index, out_last=(index==LAYER_SZ-1).
REQ-020 A transfer occurs on any edge with out_valid and out_ready both high; the index then increments by 1.
REQ-021 While out_valid=1 and out_ready=0, every output SHALL hold stable.
REQ-022 A transfer with out_last=1 SHALL move to DONE; the index SHALL NOT wrap in STREAM.
REQ-023 DONE SHALL last exactly one cycle with done=1 and out_valid=0, then go to IDLE.
REQ-024 start SHALL be ignored in STREAM and DONE, and in IDLE there is no queued request.
REQ-025 With out_ready held high, a layer SHALL stream in LAYER_SZ consecutive cycles.
REQ-026 LAYER_SZ=1: the first element SHALL carry out_last=1.

Reset
REQ-027 rst=1 SHALL force IDLE, index 0, and out_valid, out_last, busy and done to 0, with out_data and out_index at 0.
REQ-028 rst during STREAM SHALL abort the layer without a done pulse; rst overrides a simultaneous start.

Configuration
REQ-029 Macro LAYER_READER_RELU_EN defined: out_data SHALL be 0 when the snapshot element is negative (two's-complement MSB=1), otherwise the element.
REQ-030 Macro undefined: out_data SHALL be the raw snapshot element, with no added logic.
REQ-031 The macro SHALL NOT affect timing, handshake or index behaviour.

Structure
REQ-032 Shared package layer_pkg SHALL hold the default SIZE and LAYER_SZ, the ADDR_W helper function, and the reader state enum typedef.
REQ-033 Sub-module layer_index_counter (clear, increment, terminal flag at LAYER_SZ-1) SHALL implement the index.

Verification
REQ-034 LAYER_SZ=4, values={5,6,7,8}, start at cycle 0, out_ready=1 -> out_valid in cycles 1-4 with data 5,6,7,8, index 0-3, out_last in cycle 4 only, done in cycle 5, busy in cycles 1-5.
REQ-035 out_ready low in cycles 2-3 -> element index 1 held stable for 3 cycles, no element lost or duplicated, done one cycle after the index-3 transfer.
REQ-036 values changed to {0,0,0,0} in cycle 1 -> stream still 5,6,7,8.
REQ-037 rst pulsed in cycle 2 -> next cycle IDLE with all outputs 0 and no done; a new start restarts at index 0.
REQ-038 SIZE=16, values={16'hFFFF,16'h0003} -> with LAYER_READER_RELU_EN data 0,3; without it FFFF,0003.
REQ-039 start held high through STREAM -> exactly one layer streamed, busy drops after done, and no back-to-back restart while busy.

Source files
------------

// File: rtl/layer_pkg.sv
// layer_pkg: shared defaults, index-width helper and reader state type for the layer reader
package layer_pkg;
  localparam int DEF_SIZE = 16;
  localparam int DEF_LAYER_SZ = 10;
  function automatic int addr_w(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
  typedef enum logic [1:0] {IDLE, STREAM, DONE} reader_state_t;
endpackage

// File: rtl/layer_index_counter.sv
// layer_index_counter: neuron index with clear, increment and terminal flag at LAYER_SZ-1
module layer_index_counter import layer_pkg::*; #(
  parameter int LAYER_SZ = DEF_LAYER_SZ,
  localparam int ADDR_W = addr_w(LAYER_SZ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] idx,
  output logic              last
);
  assign last = idx == ADDR_W'(LAYER_SZ - 1);
  // saturate at the terminal index so the stream never wraps
  always_ff @(posedge clk)
    if (rst || clear) idx <= '0;
    else if (inc && !last) idx <= idx + 1'b1;
endmodule

// File: rtl/layer_reader.sv
// layer_reader: snapshots a parallel layer on start and streams it element by element (optional ReLU via LAYER_READER_RELU_EN)
module layer_reader import layer_pkg::*; #(
  parameter int SIZE = DEF_SIZE,
  parameter int LAYER_SZ = DEF_LAYER_SZ,
  localparam int ADDR_W = addr_w(LAYER_SZ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LAYER_SZ*SIZE-1:0] values,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE-1:0]          out_data,
  output logic [ADDR_W-1:0]        out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);
  reader_state_t     state;
  logic [SIZE-1:0]   snap [LAYER_SZ];
  logic [ADDR_W-1:0] idx;
  logic              term;
  logic [SIZE-1:0]   elem;
  logic              xfer;
  assign xfer = out_valid && out_ready;
  layer_index_counter #(.LAYER_SZ(LAYER_SZ)) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .inc  (xfer),
    .idx  (idx),
    .last (term)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state == IDLE   ? (start ? STREAM : IDLE) :
                  state == STREAM ? (xfer && term ? DONE : STREAM) : IDLE;
  // element 0 sits in the most significant slice of values
  always_ff @(posedge clk)
    if (!rst && state == IDLE && start)
      for (int k = 0; k < LAYER_SZ; k++) snap[k] <= values[(LAYER_SZ-1-k)*SIZE +: SIZE];
`ifdef LAYER_READER_RELU_EN
  assign elem = snap[idx][SIZE-1] ? '0 : snap[idx];
`else
  assign elem = snap[idx];
`endif
  assign out_valid = state == STREAM;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign out_data  = out_valid ? elem : '0;
  assign out_index = out_valid ? idx : '0;
  assign out_last  = out_valid && term;
endmodule

// File: tb/tb_layer_reader.sv
// tb_layer_reader: directed scoreboard bench for layer_reader (LAYER_SZ=4 and LAYER_SZ=1 instances)
module tb_layer_reader;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [63:0] values = '0;
  logic        out_ready = 1;
  logic        out_valid, out_last, busy, done;
  logic [15:0] out_data;
  logic [1:0]  out_index;
  logic        start1 = 0;
  logic [15:0] values1 = 16'h0009;
  logic        out_valid1, out_last1, busy1, done1;
  logic [15:0] out_data1;
  logic [0:0]  out_index1;
  int checks = 0;
  int errors = 0;
  typedef struct { logic [15:0] d; logic [1:0] i; logic l; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  layer_reader #(.SIZE(16), .LAYER_SZ(4)) dut (
    .clk(clk), .rst(rst), .start(start), .values(values),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );
  layer_reader #(.SIZE(16), .LAYER_SZ(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .values(values1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_data(out_data1),
    .out_index(out_index1), .out_last(out_last1), .busy(busy1), .done(done1)
  );

  function automatic logic [15:0] model(input logic [15:0] v);
`ifdef LAYER_READER_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams one layer from the current values; out_ready is low in cycles stall_lo..stall_hi,
  // values are cleared in cycle mod_cyc, and start stays at hold_start after cycle 0.
  task automatic run_layer(input int stall_lo, input int stall_hi, input int mod_cyc, input logic hold_start);
    exp_t e;
    int last_x = -1;
    bit got = 0;
    for (int i = 0; i < 4; i++) begin
      e.d = model(values[(3-i)*16 +: 16]);
      e.i = 2'(i);
      e.l = (i == 3);
      q.push_back(e);
    end
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    start = 1;
    out_ready = 1;
    for (int cyc = 1; cyc < 40; cyc++) begin
      tick();
      start = hold_start;
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      if (cyc == mod_cyc) values = '0;
      chk("busy", busy, 1);
      if (done) begin
        chk("done_cycle", cyc, last_x + 1);
        chk("done_q_empty", q.size(), 0);
        chk("done_valid", out_valid, 0);
        got = 1;
        break;
      end
      chk("valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        chk("data", out_data, q[0].d);
        chk("index", out_index, q[0].i);
        chk("last", out_last, q[0].l);
        if (out_ready) begin
          void'(q.pop_front());
          last_x = cyc;
        end
      end
    end
    chk("done_seen", got, 1);
    q.delete();
    out_ready = 1;
    tick();
    start = 0;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_valid", out_valid, 0);
    tick();
    chk("post2_busy", busy, 0);
  endtask

  initial begin
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);
    tick();
    rst = 0;
    tick();
    values = {16'd5, 16'd6, 16'd7, 16'd8};
    run_layer(0, -1, 0, 0);
    values = {16'd5, 16'd6, 16'd7, 16'd8};
    run_layer(2, 3, 0, 0);
    values = {16'd5, 16'd6, 16'd7, 16'd8};
    run_layer(0, -1, 1, 0);
    values = {16'hFFFF, 16'h0003, 16'h8000, 16'h7FFF};
    run_layer(0, -1, 0, 0);
    values = {16'd1, 16'd2, 16'd3, 16'd4};
    run_layer(2, 2, 0, 1);
    values = {16'd5, 16'd6, 16'd7, 16'd8};
    start = 1;
    tick();
    start = 0;
    chk("abort_valid1", out_valid, 1);
    tick();
    rst = 1;
    chk("abort_index1", out_index, 1);
    tick();
    rst = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_data", out_data, 0);
    chk("abort_index", out_index, 0);
    chk("abort_last", out_last, 0);
    tick();
    chk("abort_done2", done, 0);
    rst = 1;
    start = 1;
    tick();
    rst = 0;
    start = 0;
    chk("rst_start_valid", out_valid, 0);
    chk("rst_start_busy", busy, 0);
    values = {16'd5, 16'd6, 16'd7, 16'd8};
    run_layer(0, -1, 0, 0);
    start1 = 1;
    tick();
    start1 = 0;
    chk("one_valid", out_valid1, 1);
    chk("one_last", out_last1, 1);
    chk("one_index", out_index1, 0);
    chk("one_data", out_data1, 16'h0009);
    tick();
    chk("one_done", done1, 1);
    chk("one_done_valid", out_valid1, 0);
    tick();
    chk("one_idle_busy", busy1, 0);
    chk("one_idle_done", done1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
